// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add issue/writeback slice.
package fpu_pkg;

  localparam int FADD_LAT   = 2;
  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Result FIFO between the adder return port and the register-file write port.
// The head entry is exposed directly; valid is registered and tracks occupancy.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_entry_t               din,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic                    valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & valid;
  // A full FIFO can still accept a push in the same cycle it pops.
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign head     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push) count_nxt = count_nxt + CW'(1);
    if (do_pop)  count_nxt = count_nxt - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      count <= count_nxt;
      valid <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fadd_issue_wb.sv
// Issue/collect wrapper around the fixed-latency FP adder: hazard scoreboard,
// credit accounting against the result FIFO, and post-reset drain of stale returns.
module fadd_issue_wb
  import fpu_pkg::*;
#(
  parameter int LAT   = FADD_LAT,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] fa_adata,
  output logic [31:0] fa_bdata,
  output logic        fa_flag_in,
  output logic [4:0]  fa_address_in,
  input  logic [31:0] fa_result,
  input  logic        fa_flag_out,
  input  logic [4:0]  fa_address_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] busy,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(LAT + 1);

  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] drain;
  logic [31:0]   busy_nxt;
  logic          hz;
  logic          issue;
  logic          ret;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_ovf;
  logic          spurious;
  wb_entry_t     push_entry;
  wb_entry_t     head;

  assign fa_adata      = req_a;
  assign fa_bdata      = req_b;
  assign fa_address_in = req_rd;

  // Registered busy only: a register freed this cycle still stalls this cycle.
  assign hz        = busy[req_rs1] | busy[req_rs2] | busy[req_rd];
  assign req_ready = ~rst & ~hz & ((inflight + fifo_count) < CW'(DEPTH)) & (drain == '0);
  assign issue     = req_valid & req_ready;
  assign fa_flag_in = issue;

  // Returns are ignored while the adder flushes flags issued before reset.
  assign ret        = fa_flag_out & (drain == '0);
  assign fifo_push  = ret & (inflight != '0);
  assign spurious   = ret & (inflight == '0);
  assign push_entry = '{addr: fa_address_out, data: fa_result};
  assign fifo_pop   = wb_valid & wb_ready;

  assign wb_addr = head.addr;
  assign wb_data = head.data;

  fpu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .din      (push_entry),
    .pop      (wb_ready),
    .head     (head),
    .valid    (wb_valid),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  always_comb begin
    busy_nxt = busy;
    if (fifo_pop) busy_nxt[wb_addr] = 1'b0;
    if (issue)    busy_nxt[req_rd]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      inflight <= '0;
      drain    <= DW'(LAT);
      err      <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      inflight <= inflight + CW'(issue) - CW'(fifo_push);
      if (drain != '0) drain <= drain - DW'(1);
      if (spurious | fifo_ovf) err <= 1'b1;
    end
  end

endmodule

// File: doc/fadd_issue_wb.md
Name: fadd_issue_wb

Overview:
- Requester and collector for the pipelined FP adder: the other end of its flag/address tag interface.
- Accepts FP add requests from the decode stage with a valid/ready handshake and performs RAW/WAW hazard checks against a 32-entry busy scoreboard.
- Drives the adder's operand/flag/address inputs, captures tagged results in a result FIFO, and presents them to the FP register-file write port with a valid/ready handshake.
- Credit accounting guarantees no result is lost, because the adder pipeline cannot stall.

Parameters:
- LAT, 2, adder latency in cycles from flag_in sampled to flag_out valid; must equal the adder's pipeline depth.
- DEPTH, 4, result FIFO entries; must be >= LAT+1 for full throughput.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- req_rs1  in  5  source register of operand a
- req_rs2  in  5  source register of operand b
- req_rd  in  5  destination register
- req_a  in  32  operand a, IEEE single
- req_b  in  32  operand b, IEEE single
- fa_adata  out  32  to adder adata
- fa_bdata  out  32  to adder bdata
- fa_flag_in  out  1  to adder flag_in
- fa_address_in  out  5  to adder address_in
- fa_result  in  32  from adder result
- fa_flag_out  in  1  from adder flag_out
- fa_address_out  in  5  from adder address_out
- wb_valid  out  1  writeback entry available
- wb_ready  in  1  register file accepts the entry
- wb_addr  out  5  writeback register
- wb_data  out  32  writeback value
- busy  out  32  scoreboard, bit i = register i has a pending write
- err  out  1  sticky protocol error

Behaviour:
- Reset (async assert): busy=0, FIFO empty, wb_valid=0, inflight=0, err=0, drain counter=LAT. While rst=1: req_ready=0, fa_flag_in=0.
- Issue is combinational pass-through:
  - fa_adata=req_a, fa_bdata=req_b, fa_address_in=req_rd.
  - fa_flag_in = req_valid & req_ready.
  - The adder samples these at the same edge that the request is accepted.
- Hazard: hz = busy[req_rs1] | busy[req_rs2] | busy[req_rd], using registered busy. There is no bypass: a register cleared in the same cycle still stalls that cycle.
- Credit: req_ready = !hz & (inflight + fifo_count < DEPTH) & (drain==0). Width of the sum is clog2(DEPTH)+1 bits.
- On issue: busy[req_rd] set at the edge; inflight +1.
- Return:
  - When fa_flag_out=1 and drain==0, push {fa_address_out, fa_result} into the FIFO; inflight -1.
  - Issue and return in the same cycle leave inflight unchanged.
- Writeback:
  - FIFO head drives wb_addr/wb_data. wb_valid is registered and rises in the cycle after a push into an empty FIFO.
  - Pop on wb_valid & wb_ready; busy[wb_addr] cleared at the same edge.
  - Order is strictly FIFO, which equals issue order because latency is fixed.
- Latency: request accepted in cycle k -> fa_flag_out in k+LAT -> wb_valid in k+LAT+1 (if FIFO empty) -> busy clears at the edge ending the pop cycle.
- Throughput: one issue per cycle when hazard-free and wb_ready is held 1.
- Full FIFO with wb_ready=0: credits reach 0 and req_ready drops. The FIFO never overflows. A push to a full FIFO is impossible by construction; if it occurs, drop the push and set err.
- fa_flag_out=1 with inflight==0 (and drain==0): ignore and set err. err clears only on rst.
- Reset mid-operation: the adder has no reset, so stale flags may emerge. After rst deasserts, drain counts LAT down to 0, one per cycle. While drain!=0, fa_flag_out is ignored, no err is raised, and req_ready=0.
- wb_ready may toggle arbitrarily. wb_addr/wb_data are held stable while wb_valid=1 and not popped.

Decomposition:
- Package fpu_pkg: FADD_LAT=2, REG_ADDR_W=5, WORD_W=32, and the typedef wb_entry_t {addr[4:0], data[31:0]}.
- Sub-module fpu_result_fifo:
  - Parameterised DEPTH, storing wb_entry_t.
  - Push/pop with simultaneous push+pop.
  - Registered valid, count output, overflow flag.
- Scoreboard, credit counter and drain counter stay in the top.

Test Plan:
- Single add: rs1=1, rs2=2, rd=3, a=0x3F800000, b=0x40000000, issued in cycle 0 (adder model, LAT=2). Required: fa_flag_in=1 in cycle 0; wb_valid=1, wb_addr=3, wb_data=0x40400000 in cycle 3; busy[3]=1 during cycles 1-3 and 0 from cycle 4.
- RAW stall: issue rd=5, then a request with rs1=5 on the next cycle. Required: req_ready=0 until the edge where the rd=5 writeback pops; the second request issues the cycle after busy[5] clears.
- Back-pressure: wb_ready=0 while issuing 6 independent requests (rd=10..15). Required: exactly 4 accepted, req_ready=0 afterwards, no err. Raising wb_ready drains rd=10,11,12,13 in order, then the remaining 2 issue.
- Full throughput: 8 independent requests with wb_ready=1. Required: one accept per cycle, 8 consecutive wb_valid cycles in issue order.
- Reset mid-flight: assert rst one cycle after issuing rd=7. Required: busy=0, wb_valid=0, req_ready=0 for 2 cycles after deassert, stale fa_flag_out ignored, err=0.
- Spurious return: drive fa_flag_out=1 with nothing in flight and drain=0. Required: err=1 and held until rst; FIFO stays empty.
